debounce_multi: RTL
===================

# debounce_multi

Parametrised multi-channel debouncer for mechanical buttons and switches on the board I/O. Each channel synchronises its raw pin, qualifies both press and release against a stable-cycle threshold, and produces a clean level plus one-cycle rise, fall and long-press pulses. It sits between the top-level pin inputs and the control FSMs, and replaces single-button, press-only debouncing wherever more than one input or release qualification is needed.

## Interface
- `N_CH`, 4, number of independent channels.
- `SYNC_STAGES`, 2, synchroniser flops per channel; legal values are 2 or more.
- `STABLE_CYCLES`, 32, consecutive agreeing samples required to change the debounced level; legal values are 1 or more.
- `LONG_CYCLES`, 0, cycles the level must stay high before `long_press` pulses; 0 disables long-press detection.
- `SYMMETRIC`, 1; 1 means release is also qualified; 0 means release is immediate (legacy behaviour).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `button`  in  N_CH  raw asynchronous pin inputs.
- `level`  out  N_CH  debounced level.
- `rise`  out  N_CH  one-cycle pulse when `level` goes 0→1.
- `fall`  out  N_CH  one-cycle pulse when `level` goes 1→0.
- `long_press`  out  N_CH  one-cycle pulse when a hold reaches `LONG_CYCLES`.

## Operation
- Channels are fully independent. There is no cross-channel interaction.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per channel; the last stage is `sample`.
- Per-channel FSM states:
  - LOW: `level`=0. Move to QUAL_H when `sample`=1.
  - QUAL_H: `level`=0; `stab_cnt` increments each cycle `sample`=1.
    - If `sample`=0: return to LOW and clear the counter.
    - When the count reaches `STABLE_CYCLES` with `sample` still 1: go to HIGH and pulse `rise`.
  - HIGH: `level`=1. Move to QUAL_L when `sample`=0.
    - If `SYMMETRIC`=0: go directly to LOW on the first `sample`=0 and pulse `fall`.
  - QUAL_L: `level`=1; mirror of QUAL_H.
    - If `sample`=1: return to HIGH and clear the counter.
    - When `STABLE_CYCLES` consecutive zeros are reached: go to LOW and pulse `fall`.
- Any sample that agrees with the current `level` during qualification aborts it and clears `stab_cnt`. A glitch therefore never half-counts.
- `stab_cnt` width is `$clog2(STABLE_CYCLES+1)`; it never wraps.
- `hold_cnt` (width `$clog2(LONG_CYCLES+1)`):
  - Counts while `level`=1, including during QUAL_L.
  - Saturates at `LONG_CYCLES`; `long_press` pulses exactly once, on the cycle it first reaches `LONG_CYCLES`.
  - Cleared when `level`=0.
  - With `LONG_CYCLES`=0 the counter logic is omitted and `long_press` is tied to 0.
- `rise`, `fall` and `long_press` never assert for more than one cycle. `rise` and `fall` never assert in the same cycle on one channel.

## Timing
- Reset clears all synchroniser flops, counters and FSMs (state LOW). All outputs read 0 on the first edge with `reset`=1.
  - Reset mid-qualification or while HIGH produces no `fall` pulse.
- Press latency from a clean pin transition to `level`/`rise`: `SYNC_STAGES` + `STABLE_CYCLES` rising edges.
- Release latency: the same when `SYMMETRIC`=1; `SYNC_STAGES` + 1 edges when `SYMMETRIC`=0.
- `long_press` fires `LONG_CYCLES` edges after `rise`, provided no `fall` occurs before then.
- A pin held high through reset release yields `rise` `SYNC_STAGES` + `STABLE_CYCLES` edges after `reset` deasserts.
- All outputs are registered; there is no combinational path from `button` to any output.

## Structure
- Shared package `debounce_pkg`: FSM state encoding (LOW, QUAL_H, HIGH, QUAL_L as 2-bit localparams) and a clog2 helper if the toolchain needs it.
- Sub-module `debounce_channel`: one synchroniser, FSM, `stab_cnt` and `hold_cnt`, with the same parameters minus `N_CH`.
- Top level is a generate loop of `N_CH` instances.

## Test plan
All scenarios use `N_CH`=2, `SYNC_STAGES`=2, `STABLE_CYCLES`=8, `LONG_CYCLES`=20 unless stated.
- Clean press on ch0 → `level[0]` and `rise[0]` assert on edge 10 after the pin rises; `rise[0]` is low on edge 11; ch1 stays 0.
- Bounce: pin high 5 cycles, low 1, then held high → no `rise` during the bounce; `rise[0]` fires 10 edges after the final low→high.
- Release with `SYMMETRIC`=1: a 3-cycle low glitch while HIGH → no `fall`, `level` stays 1; then held low → `fall[0]` and `level`=0 10 edges after the pin falls.
- Long press: held high → `rise` at edge 10, `long_press` once at edge 30, nothing further while held. Release and re-press → `long_press` repeats at the same offset.
- `SYMMETRIC`=0: pin falls while HIGH → `level`=0 and `fall` on edge 3; press still takes 10 edges.
- `reset` pulsed during ch0 QUAL_H and ch1 HIGH → all outputs 0 on the next edge with no `fall`. With ch1 pin still high, ch1 `rise` fires 10 edges after reset deasserts.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: per-channel FSM state
// encoding and a small state-decode helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_QUAL_H = 2'd1,
    ST_HIGH   = 2'd2,
    ST_QUAL_L = 2'd3
  } deb_state_e;

  // The debounced level is high in HIGH and while a release is being qualified.
  function automatic logic state_level(input deb_state_e s);
    return (s == ST_HIGH) || (s == ST_QUAL_L);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, press/release qualification FSM and an
// optional long-press hold counter. All outputs come straight from flops.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 32,
  parameter int LONG_CYCLES   = 0,
  parameter int SYMMETRIC     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam int            SW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sample;

  deb_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_stab_cnt, w_stab_nxt;
  logic          w_rise_nxt, w_fall_nxt;
  logic          r_level, r_rise, r_fall;

  always_ff @(posedge clk) begin
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], button};
  end

  assign w_sample = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_LOW;
      r_stab_cnt <= '0;
      r_level    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_level    <= state_level(w_state_nxt);
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
    end
  end

  // The sample that leaves LOW/HIGH already counts as the first agreeing one,
  // so a threshold of 1 transitions straight through without qualifying.
  always_comb begin
    w_state_nxt = r_state;
    w_stab_nxt  = r_stab_cnt;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      ST_LOW: begin
        if (w_sample) begin
          if (STABLE_CYCLES == 1) begin
            w_state_nxt = ST_HIGH;
            w_rise_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_QUAL_H;
            w_stab_nxt  = SW'(1);
          end
        end
      end
      ST_QUAL_H: begin
        if (!w_sample) begin
          w_state_nxt = ST_LOW;
          w_stab_nxt  = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_HIGH;
          w_stab_nxt  = '0;
          w_rise_nxt  = 1'b1;
        end else begin
          w_stab_nxt  = r_stab_cnt + SW'(1);
        end
      end
      ST_HIGH: begin
        if (!w_sample) begin
          if ((SYMMETRIC == 0) || (STABLE_CYCLES == 1)) begin
            w_state_nxt = ST_LOW;
            w_fall_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_QUAL_L;
            w_stab_nxt  = SW'(1);
          end
        end
      end
      ST_QUAL_L: begin
        if (w_sample) begin
          w_state_nxt = ST_HIGH;
          w_stab_nxt  = '0;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_LOW;
          w_stab_nxt  = '0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_stab_nxt  = r_stab_cnt + SW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOW;
        w_stab_nxt  = '0;
      end
    endcase
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

  generate
    if (LONG_CYCLES > 0) begin : g_long
      localparam int            HW        = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

      logic [HW-1:0] r_hold_cnt;
      logic          r_long;

      // Counts edges after level went high; the pulse lands on the edge the
      // count first reaches the limit, and saturation keeps it from repeating.
      always_ff @(posedge clk) begin
        if (reset || !r_level) begin
          r_hold_cnt <= '0;
          r_long     <= 1'b0;
        end else begin
          if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + HW'(1);
          r_long <= (r_hold_cnt == HOLD_LAST);
        end
      end

      assign long_press = r_long;
    end else begin : g_no_long
      assign long_press = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Array of independent debounced channels sitting between raw board pins and
// the control logic.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 32,
  parameter int LONG_CYCLES   = 0,
  parameter int SYMMETRIC     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] long_press
);

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .LONG_CYCLES  (LONG_CYCLES),
        .SYMMETRIC    (SYMMETRIC)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .button    (button[g]),
        .level     (level[g]),
        .rise      (rise[g]),
        .fall      (fall[g]),
        .long_press(long_press[g])
      );
    end
  endgenerate

endmodule
